// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single data-memory port between the CPU path (port C) and the
// debug/loader path (port D). One transaction is in flight at a time:
// IDLE -> ISSUE (mem_en) -> WAIT (MEM_LAT cycles) -> RESP (rsp_valid) -> IDLE.
// Ties in IDLE are resolved round-robin by default.
// Optional macro ARB_CPU_PRIO_EN: when defined, port C always wins a tie.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is combinational, only ever high in IDLE
// (never during reset), and at most one port sees it. A requester keeps its
// payload stable while valid is high without ready; dropping valid before
// ready cancels the request. rsp_valid is a single-cycle pulse and rsp_rdata
// is qualified by it (writes respond with rsp_rdata = 0).
module dmem_port_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              c_req_valid,
  input  logic              c_req_we,
  input  logic [ADDR_W-1:0] c_req_addr,
  input  logic [DATA_W-1:0] c_req_wdata,
  output logic              c_req_ready,
  output logic              c_rsp_valid,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // MEM_LAT is at most 15, so four bits cover the wait counter.
  localparam int               CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q;
  logic                owner_q;      // 1 = port D owns the transaction
  logic                last_q;       // 1 = port D was granted last
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                grant_c, grant_d, accept;
  logic                rdata_capture;

  // Arbitration between the two requesters; only meaningful in IDLE outside reset
  always_comb begin
    grant_c = 1'b0;
    grant_d = 1'b0;
    if (state_q == S_IDLE && !reset) begin
      if (c_req_valid && d_req_valid) begin
`ifdef ARB_CPU_PRIO_EN
        grant_c = 1'b1;
`else
        grant_c = last_q;
        grant_d = !last_q;
`endif
      end else begin
        grant_c = c_req_valid;
        grant_d = d_req_valid;
      end
    end
  end

  assign accept        = grant_c | grant_d;
  assign rdata_capture = (state_q == S_WAIT) && (cnt_q == CNT_ONE);

  // State register
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = LAT_LOAD;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Transaction payload, ownership, round-robin history and response data
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        we_q    <= grant_d ? d_req_we    : c_req_we;
        addr_q  <= grant_d ? d_req_addr  : c_req_addr;
        wdata_q <= grant_d ? d_req_wdata : c_req_wdata;
        owner_q <= grant_d;
        last_q  <= grant_d;
      end
      if (rdata_capture) begin
        rdata_q <= we_q ? '0 : mem_rdata;
      end
    end
  end

  // Outputs decoded from the current state and the latched transaction
  always_comb begin
    c_req_ready = grant_c;
    d_req_ready = grant_d;
    mem_en      = (state_q == S_ISSUE);
    mem_we      = (state_q == S_ISSUE) && we_q;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    c_rsp_valid = (state_q == S_RESP) && !owner_q;
    d_rsp_valid = (state_q == S_RESP) && owner_q;
    rsp_rdata   = rdata_q;
    busy        = (state_q != S_IDLE);
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic on both ports compared every cycle against a
// transaction-timeline reference model. A second instance with MEM_LAT=3
// covers the longer-latency timing.
module tb_dmem_port_arbiter;
  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int LAT = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- main DUT (MEM_LAT=1) ----------------
  logic          c_req_valid, c_req_we, c_req_ready, c_rsp_valid;
  logic [AW-1:0] c_req_addr;
  logic [DW-1:0] c_req_wdata;
  logic          d_req_valid, d_req_we, d_req_ready, d_rsp_valid;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata;
  logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [1:0]    dbg_state;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk_in(clk), .reset(rst),
    .c_req_valid(c_req_valid), .c_req_we(c_req_we), .c_req_addr(c_req_addr),
    .c_req_wdata(c_req_wdata), .c_req_ready(c_req_ready), .c_rsp_valid(c_rsp_valid),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid),
    .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .dbg_state_o(dbg_state)
  );

  // ---------------- second DUT (MEM_LAT=3), port D unused ----------------
  logic          l3_rst, l3_cv, l3_cwe, l3_c_ready, l3_c_rsp, l3_d_ready, l3_d_rsp;
  logic [AW-1:0] l3_caddr, l3_mem_addr;
  logic [DW-1:0] l3_cwd, l3_rsp_rdata, l3_mem_wdata, l3_mem_rdata;
  logic          l3_mem_en, l3_mem_we, l3_busy;
  logic [1:0]    l3_dbg;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut_l3 (
    .clk_in(clk), .reset(l3_rst),
    .c_req_valid(l3_cv), .c_req_we(l3_cwe), .c_req_addr(l3_caddr),
    .c_req_wdata(l3_cwd), .c_req_ready(l3_c_ready), .c_rsp_valid(l3_c_rsp),
    .d_req_valid(1'b0), .d_req_we(1'b0), .d_req_addr('0),
    .d_req_wdata('0), .d_req_ready(l3_d_ready), .d_rsp_valid(l3_d_rsp),
    .rsp_rdata(l3_rsp_rdata), .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr),
    .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata), .busy(l3_busy), .dbg_state_o(l3_dbg)
  );

  // ---------------- memory content ----------------
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    if (a == AW'(5)) return 32'hDEADBEEF;
    return {a[7:0], ~a[7:0], 8'h5A, a[7:0]};
  endfunction

  // Main RAM: read data appears exactly one cycle after a read strobe,
  // otherwise a poison value so a mistimed capture shows up.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) ram[i] = init_word(AW'(i));
  always @(posedge clk) begin
    mem_rdata <= (mem_en && !mem_we) ? ram[mem_addr] : 32'hBAD0BAD0;
    if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
  end

  // Latency-3 read-only memory: three-stage pipeline of the initial content
  logic [DW-1:0] l3_p0, l3_p1;
  always @(posedge clk) begin
    l3_p0        <= l3_mem_en ? init_word(l3_mem_addr) : 32'hBAD0BAD0;
    l3_p1        <= l3_p0;
    l3_mem_rdata <= l3_p1;
  end

  // ---------------- scoreboard / checks ----------------
  int total = 0;
  int bad   = 0;

  task automatic check1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check32(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A granted transaction is tracked as an offset k from its accept edge:
  // memory strobe at k=1, response at k=LAT+2, idle again afterwards.
  bit            chk_en   = 1'b0;
  bit            m_active = 1'b0;
  int            m_k      = 0;
  bit            m_owner_d, m_we;
  bit            m_last_d = 1'b1;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata  = '0;
  logic [DW-1:0] exp_mem [int];
  logic [DW-1:0] exp_q [$];

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (exp_mem.exists(int'(a))) return exp_mem[int'(a)];
    return init_word(a);
  endfunction

  function automatic void pick(output bit gc, output bit gd);
    gc = 1'b0;
    gd = 1'b0;
    if (!m_active && !rst) begin
      if (c_req_valid && d_req_valid) begin
`ifdef ARB_CPU_PRIO_EN
        gc = 1'b1;
`else
        if (m_last_d) gc = 1'b1;
        else          gd = 1'b1;
`endif
      end else if (c_req_valid) gc = 1'b1;
      else if (d_req_valid)     gd = 1'b1;
    end
  endfunction

  // Model advance on every rising edge, from the inputs held across it
  always @(posedge clk) begin
    bit gc, gd;
    if (rst) begin
      m_active = 1'b0;
      m_last_d = 1'b1;
      m_rdata  = '0;
      exp_q.delete();
    end else if (m_active) begin
      if (m_k == LAT + 1 && exp_q.size() > 0) m_rdata = exp_q.pop_front();
      if (m_k == LAT + 2) m_active = 1'b0;
      else                m_k++;
    end else begin
      pick(gc, gd);
      if (gc || gd) begin
        m_owner_d = gd;
        m_we      = gd ? d_req_we    : c_req_we;
        m_addr    = gd ? d_req_addr  : c_req_addr;
        m_wdata   = gd ? d_req_wdata : c_req_wdata;
        m_last_d  = gd;
        m_active  = 1'b1;
        m_k       = 1;
        if (m_we) begin
          exp_mem[int'(m_addr)] = m_wdata;
          exp_q.push_back('0);
        end else begin
          exp_q.push_back(model_read(m_addr));
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    bit gc, gd, e_en, e_rsp;
    if (chk_en) begin
      pick(gc, gd);
      e_en  = m_active && (m_k == 1);
      e_rsp = m_active && (m_k == LAT + 2);
      check1("m_c_ready", c_req_ready, gc);
      check1("m_d_ready", d_req_ready, gd);
      check1("m_busy", busy, m_active);
      check1("m_mem_en", mem_en, e_en);
      check1("m_mem_we", mem_we, e_en && m_we);
      if (e_en) begin
        check32("m_mem_addr", 32'(mem_addr), 32'(m_addr));
        if (m_we) check32("m_mem_wdata", mem_wdata, m_wdata);
      end
      check1("m_c_rsp", c_rsp_valid, e_rsp && !m_owner_d);
      check1("m_d_rsp", d_rsp_valid, e_rsp && m_owner_d);
      check32("m_rsp_rdata", rsp_rdata, m_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    c_req_valid = 1'b0; c_req_we = 1'b0; c_req_addr = '0; c_req_wdata = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Raise one request at the start of a cycle; it must be granted that cycle
  task automatic start_req(input string tag, input bit port_d, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
    @(posedge clk); #1;
    if (port_d) begin
      d_req_valid = 1'b1; d_req_we = we; d_req_addr = a; d_req_wdata = wd;
    end else begin
      c_req_valid = 1'b1; c_req_we = we; c_req_addr = a; c_req_wdata = wd;
    end
    @(negedge clk);
    check1({tag, "_ready"}, port_d ? d_req_ready : c_req_ready, 1'b1);
    check1({tag, "_other_ready"}, port_d ? c_req_ready : d_req_ready, 1'b0);
  endtask

  // Follow an accepted single transaction (MEM_LAT=1) through cycles 1..4
  task automatic follow_txn(input string tag, input bit port_d, input bit we,
                            input logic [AW-1:0] a, input logic [DW-1:0] exp_rd);
    @(posedge clk); #1;
    c_req_valid = 1'b0;
    d_req_valid = 1'b0;
    @(negedge clk);
    check1({tag, "_mem_en"}, mem_en, 1'b1);
    check1({tag, "_mem_we"}, mem_we, we);
    check32({tag, "_mem_addr"}, 32'(mem_addr), 32'(a));
    @(negedge clk);
    check1({tag, "_wait_busy"}, busy, 1'b1);
    check1({tag, "_wait_en"}, mem_en, 1'b0);
    @(negedge clk);
    check1({tag, "_c_rsp"}, c_rsp_valid, !port_d);
    check1({tag, "_d_rsp"}, d_rsp_valid, port_d);
    check32({tag, "_rdata"}, rsp_rdata, exp_rd);
    @(negedge clk);
    check1({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  task automatic rand_req(output logic v, output logic we,
                          output logic [AW-1:0] a, output logic [DW-1:0] wd);
    v  = 1'b1;
    we = 1'($urandom_range(0, 1));
    a  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(0, (1 << AW) - 1))
                                     : AW'($urandom_range(0, 15));
    wd = $urandom;
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] grants [4];
  int         ng;
  bit         c_acc, d_acc;

  initial begin
    rst = 1'b1;
    clear_inputs();
    l3_rst = 1'b1; l3_cv = 1'b0; l3_cwe = 1'b0; l3_caddr = '0; l3_cwd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset state, with reset still asserted
    @(negedge clk);
    check1("rst_busy", busy, 1'b0);
    check1("rst_mem_en", mem_en, 1'b0);
    check1("rst_c_rsp", c_rsp_valid, 1'b0);
    check1("rst_d_rsp", d_rsp_valid, 1'b0);
    check32("rst_rdata", rsp_rdata, 32'h0);
    check32("rst_mem_addr", 32'(mem_addr), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    l3_rst = 1'b0;

    // 1: single CPU read of addr 5
    start_req("t1", 1'b0, 1'b0, AW'(5), '0);
    follow_txn("t1", 1'b0, 1'b0, AW'(5), 32'hDEADBEEF);

    // 2: debug write then CPU read-back
    start_req("t2w", 1'b1, 1'b1, AW'(9), 32'h12345678);
    follow_txn("t2w", 1'b1, 1'b1, AW'(9), 32'h0);
    start_req("t2r", 1'b0, 1'b0, AW'(9), '0);
    follow_txn("t2r", 1'b0, 1'b0, AW'(9), 32'h12345678);

    // 3: both ports valid continuously from reset
    pulse_reset();
    c_req_valid = 1'b1; c_req_we = 1'b0; c_req_addr = AW'(1);
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = AW'(2);
    ng = 0;
    for (int i = 0; i < 100 && ng < 4; i++) begin
      @(negedge clk);
      if (c_req_ready) begin grants[ng] = 2'd0; ng++; end
      else if (d_req_ready) begin grants[ng] = 2'd1; ng++; end
    end
    @(posedge clk); #1;
    clear_inputs();
    if (ng < 4) begin
      total++;
      bad++;
      $display("FAIL t3_timeout: got %0d grants want 4", ng);
    end else begin
`ifdef ARB_CPU_PRIO_EN
      check32("t3_g0", 32'(grants[0]), 32'd0);
      check32("t3_g1", 32'(grants[1]), 32'd0);
      check32("t3_g2", 32'(grants[2]), 32'd0);
      check32("t3_g3", 32'(grants[3]), 32'd0);
`else
      check32("t3_g0", 32'(grants[0]), 32'd0);
      check32("t3_g1", 32'(grants[1]), 32'd1);
      check32("t3_g2", 32'(grants[2]), 32'd0);
      check32("t3_g3", 32'(grants[3]), 32'd1);
`endif
    end
    repeat (8) @(posedge clk);

    // 4: MEM_LAT=3 single read on the second instance
    @(posedge clk); #1;
    l3_cv = 1'b1; l3_cwe = 1'b0; l3_caddr = AW'(12);
    @(negedge clk);
    check1("t4_ready", l3_c_ready, 1'b1);
    check1("t4_d_ready", l3_d_ready, 1'b0);
    check1("t4_busy_c0", l3_busy, 1'b0);
    @(posedge clk); #1;
    l3_cv = 1'b0;
    @(negedge clk);
    check1("t4_en_c1", l3_mem_en, 1'b1);
    check1("t4_we_c1", l3_mem_we, 1'b0);
    check32("t4_addr_c1", 32'(l3_mem_addr), 32'd12);
    check32("t4_wdata_c1", l3_mem_wdata, 32'h0);
    check1("t4_busy_c1", l3_busy, 1'b1);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check1("t4_busy_wait", l3_busy, 1'b1);
      check1("t4_en_wait", l3_mem_en, 1'b0);
      check1("t4_rsp_wait", l3_c_rsp, 1'b0);
    end
    @(negedge clk);
    check1("t4_rsp_c5", l3_c_rsp, 1'b1);
    check1("t4_drsp_c5", l3_d_rsp, 1'b0);
    check1("t4_busy_c5", l3_busy, 1'b1);
    check32("t4_rdata_c5", l3_rsp_rdata, init_word(AW'(12)));
    @(negedge clk);
    check1("t4_busy_c6", l3_busy, 1'b0);

    // 5: reset during WAIT of a read, then a normal request
    start_req("t5", 1'b0, 1'b0, AW'(4), '0);
    @(posedge clk); #1;
    c_req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    c_req_valid = 1'b1; c_req_we = 1'b0; c_req_addr = AW'(7);
    @(negedge clk);
    check1("t5_busy_after_rst", busy, 1'b0);
    check1("t5_no_rsp", c_rsp_valid, 1'b0);
    check1("t5_ready_after_rst", c_req_ready, 1'b1);
    follow_txn("t5b", 1'b0, 1'b0, AW'(7), init_word(AW'(7)));

    // 6: D drops its request in the cycle C is granted
    pulse_reset();
    c_req_valid = 1'b1; c_req_we = 1'b0; c_req_addr = AW'(2);
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = AW'(3);
    @(negedge clk);
    check1("t6_c_ready", c_req_ready, 1'b1);
    check1("t6_d_ready", d_req_ready, 1'b0);
    follow_txn("t6", 1'b0, 1'b0, AW'(2), init_word(AW'(2)));
    repeat (2) begin
      @(negedge clk);
      check1("t6_no_d_busy", busy, 1'b0);
      check1("t6_no_d_rsp", d_rsp_valid, 1'b0);
    end

    // Randomized traffic on both ports with occasional resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      c_acc = c_req_valid && c_req_ready;
      d_acc = d_req_valid && d_req_ready;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 149) == 0);
      if (!c_req_valid || c_acc) begin
        if ($urandom_range(0, 2) == 0) rand_req(c_req_valid, c_req_we, c_req_addr, c_req_wdata);
        else c_req_valid = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        c_req_valid = 1'b0;
      end
      if (!d_req_valid || d_acc) begin
        if ($urandom_range(0, 2) == 0) rand_req(d_req_valid, d_req_we, d_req_addr, d_req_wdata);
        else d_req_valid = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        d_req_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    repeat (10) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory (DRAM) port between two requesters: the CPU load/store path (port C) and the debug/loader path (port D).
- Accepts one transaction at a time, issues it to the memory, waits the fixed memory latency, then returns a response to the requester that owns it.
- Sits between the CPU data interface and the DRAM instance inside the SoC top.

Parameters:
- ADDR_W, 11, word-address width driven to the DRAM.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to mem_rdata valid; legal values are 1 to 15.

Ports:
- clk_in  in  1  single system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- c_req_valid  in  1  CPU request valid.
- c_req_we  in  1  CPU request is a write.
- c_req_addr  in  ADDR_W  CPU word address.
- c_req_wdata  in  DATA_W  CPU write data.
- c_req_ready  out  1  CPU request accepted this cycle.
- c_rsp_valid  out  1  CPU response pulse.
- d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_ready, d_rsp_valid: same as the c_* ports, for the debug port.
- rsp_rdata  out  DATA_W  response data, shared by both ports; qualified by c_rsp_valid or d_rsp_valid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock is clk_in. Reset is synchronous and active-high.
- Reset values:
  - FSM in IDLE; all outputs 0; rsp_rdata 0.
  - last_grant = D, so the first tie goes to C.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - c_req_ready and d_req_ready are combinational and asserted only in IDLE; at most one is high.
  - Only one valid: that port is granted.
  - Both valid: grant the port that is not last_grant (round-robin).
  - A transfer occurs on an edge where valid & ready. At that edge: latch we, addr and wdata plus the owner id; update last_grant; go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE (1 cycle):
  - mem_en = 1, with mem_we, mem_addr and mem_wdata driven from registers.
  - Go to WAIT with wait counter = MEM_LAT.
- WAIT (MEM_LAT cycles):
  - mem_en = 0; counter decrements each cycle.
  - In the cycle where the counter equals 1: capture mem_rdata into rsp_rdata if the transaction is a read, or 0 if it is a write; then go to RESP.
- RESP (1 cycle):
  - The owner's rsp_valid = 1. Writes also get an rsp_valid acknowledge, with rsp_rdata = 0.
  - Then go to IDLE.
- Timing with MEM_LAT=1:
  - Accept at cycle 0, mem_en at cycle 1, rsp_valid at cycle 3, ready again at cycle 4.
  - Occupancy is MEM_LAT+3 cycles per transaction.
- Handshake rules:
  - A requester holds valid and its payload stable until ready.
  - Dropping valid before ready is permitted and simply cancels that request; nothing is latched.
- rsp_rdata holds its value between responses.
- Reset mid-transaction, in any state:
  - The FSM returns to IDLE on the next edge and the transaction is dropped.
  - mem_en is 0 from the cycle after the reset edge, and no rsp_valid is generated.
- Simultaneous reset and request valid: reset wins; no grant.
- Out-of-range addresses are not checked and are passed straight through.

Optional Feature:
- Macro ARB_CPU_PRIO_EN.
- Defined: port C has fixed priority whenever both ports are valid in IDLE; last_grant is ignored.
- Undefined: round-robin, as described in Behaviour.

Test Plan:
1. Single CPU read, MEM_LAT=1, mem model returns 32'hDEADBEEF for addr 5 -> c_req_ready high at cycle 0; mem_en=1, mem_we=0, mem_addr=5 at cycle 1; c_rsp_valid=1 with rsp_rdata=32'hDEADBEEF at cycle 3; d_rsp_valid stays 0.
2. Debug write of 32'h12345678 to addr 9, then CPU read of addr 9 -> d_rsp_valid with rsp_rdata=0; then c_rsp_valid with rsp_rdata=32'h12345678.
3. Both ports valid continuously for 4 transactions from reset -> grant order C, D, C, D. With ARB_CPU_PRIO_EN defined -> order C, C, C, C.
4. MEM_LAT=3, single read -> mem_en at cycle 1; rsp_valid at cycle 5; busy high for cycles 1 through 5.
5. Reset asserted during the WAIT state of a read -> no rsp_valid; busy=0 and ready available in the cycle after the reset edge; the next request completes normally.
6. Request valid dropped in the same cycle a grant goes to the other port -> only the granted port's transaction occurs; the dropped port gets no response.
